// File: rtl/xilinx_pcie_pkg.sv
// xilinx_pcie_pkg: TLP format/type codes, tkeep masks, TX FSM states and completion byte-count helpers
package xilinx_pcie_pkg;
  localparam logic [6:0] MRD32   = 7'b000_0000;
  localparam logic [6:0] MWR32   = 7'b100_0000;
  localparam logic [6:0] CPL     = 7'b000_1010;
  localparam logic [6:0] CPLD    = 7'b100_1010;
  localparam logic [6:0] IO_RD32 = 7'b000_0010;
  localparam logic [6:0] IO_WR32 = 7'b100_0010;
  localparam logic [15:0] KEEP_3DW = 16'h0FFF;
  localparam logic [15:0] KEEP_4DW = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, CPL_RD, CPL_SEND, MRD_SEND} state_e;
  function automatic logic [11:0] calc_byte_count(input logic [3:0] be);
    casez (be)
      4'b1??1:                   return 12'd4;
      4'b01?1, 4'b1?10:          return 12'd3;
      4'b0011, 4'b0110, 4'b1100: return 12'd2;
      default:                   return 12'd1;
    endcase
  endfunction
  function automatic logic [1:0] calc_lower_lo(input logic [3:0] be);
    return be[0] ? 2'b00 : be[1] ? 2'b01 : be[2] ? 2'b10 : be[3] ? 2'b11 : 2'b00;
  endfunction
endpackage

// File: rtl/pcie_cpl_bc_calc.sv
// pcie_cpl_bc_calc: completion byte count and lower address from first-DW byte enables
module pcie_cpl_bc_calc
  import xilinx_pcie_pkg::*;
(
  input  logic [3:0]  be,
  input  logic [6:2]  addr,
  output logic [11:0] byte_count,
  output logic [6:0]  lower_addr
);
  always_comb begin
    byte_count = calc_byte_count(be);
    lower_addr = {addr, calc_lower_lo(be)};
  end
endmodule

// File: rtl/xilinx_pcie_tx_ep.sv
// xilinx_pcie_tx_ep: single-beat TX engine emitting Cpl/CplD answers and DMA MRd32 requests on a 128-bit AXIS
module xilinx_pcie_tx_ep
  import xilinx_pcie_pkg::*;
#(
  parameter int P_DATA_WIDTH = 128,
  parameter int P_RD_LATENCY = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [15:0]  cfg_completer_id,
  input  logic         req_compl,
  input  logic         req_compl_wd,
  input  logic [2:0]   req_tc,
  input  logic         req_td,
  input  logic         req_ep,
  input  logic [1:0]   req_attr,
  input  logic [9:0]   req_len,
  input  logic [15:0]  req_rid,
  input  logic [7:0]   req_tag,
  input  logic [7:0]   req_be,
  input  logic [31:0]  req_addr,
  output logic         compl_done,
  output logic [10:0]  rd_addr,
  output logic         rd_en,
  input  logic [31:0]  rd_data,
  input  logic         dma_rd_valid,
  output logic         dma_rd_ready,
  input  logic [31:0]  dma_rd_addr,
  input  logic [9:0]   dma_rd_len,
  output logic [7:0]   dma_rd_tag,
  output logic [127:0] s_axis_tx_tdata,
  output logic [15:0]  s_axis_tx_tkeep,
  output logic         s_axis_tx_tlast,
  output logic [3:0]   s_axis_tx_tuser,
  output logic         s_axis_tx_tvalid,
  input  logic         s_axis_tx_tready
);
  if (P_DATA_WIDTH != 128) begin : g_bad_width
    $error("xilinx_pcie_tx_ep: only P_DATA_WIDTH = 128 is supported");
  end
  if (P_RD_LATENCY < 1 || P_RD_LATENCY > 4) begin : g_bad_latency
    $error("xilinx_pcie_tx_ep: P_RD_LATENCY must be 1..4");
  end
  localparam logic [2:0] LAT = 3'(P_RD_LATENCY);
  state_e       state_q, state_d;
  logic         compl_pending_q, compl_pending_d;
  logic         wd_flag_q, wd_flag_d;
  logic [2:0]   lat_q, lat_d;
  logic [31:0]  data_q, data_d;
  logic [7:0]   tag_q, tag_d;
  logic [29:0]  mrd_addr_q, mrd_addr_d;
  logic [9:0]   mrd_len_q, mrd_len_d;
  logic [11:0]  byte_count;
  logic [6:0]   lower_addr;
  logic [127:0] cpl_beat, mrd_beat;
  logic         unused_bits;
  assign unused_bits = ^{req_len, req_be[7:4], req_addr[31:13], req_addr[1:0], dma_rd_addr[1:0]};
  pcie_cpl_bc_calc u_bc (
    .be         (req_be[3:0]),
    .addr       (req_addr[6:2]),
    .byte_count (byte_count),
    .lower_addr (lower_addr)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= IDLE;
      compl_pending_q <= 1'b0;
      wd_flag_q       <= 1'b0;
      lat_q           <= '0;
      data_q          <= '0;
      tag_q           <= '0;
      mrd_addr_q      <= '0;
      mrd_len_q       <= '0;
    end else begin
      state_q         <= state_d;
      compl_pending_q <= compl_pending_d;
      wd_flag_q       <= wd_flag_d;
      lat_q           <= lat_d;
      data_q          <= data_d;
      tag_q           <= tag_d;
      mrd_addr_q      <= mrd_addr_d;
      mrd_len_q       <= mrd_len_d;
    end
  end
  always_comb begin
    state_d         = state_q;
    compl_pending_d = compl_pending_q;
    wd_flag_d       = wd_flag_q;
    lat_d           = lat_q;
    data_d          = data_q;
    tag_d           = tag_q;
    mrd_addr_d      = mrd_addr_q;
    mrd_len_d       = mrd_len_q;
    case (state_q)
      IDLE:
        if (compl_pending_q) begin
          state_d = wd_flag_q ? CPL_RD : CPL_SEND;
          lat_d   = LAT;
        end else if (dma_rd_valid && !req_compl) begin
          state_d    = MRD_SEND;
          mrd_addr_d = dma_rd_addr[31:2];
          mrd_len_d  = dma_rd_len;
        end
      CPL_RD: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          data_d  = rd_data;
          state_d = CPL_SEND;
        end
      end
      CPL_SEND:
        if (s_axis_tx_tready) begin
          compl_pending_d = 1'b0;
          state_d         = IDLE;
        end
      MRD_SEND:
        if (s_axis_tx_tready) begin
          tag_d   = tag_q + 8'd1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
    // a new request pulse wins over the clear of the one just retired
    if (req_compl) begin
      compl_pending_d = 1'b1;
      wd_flag_d       = req_compl_wd;
    end
  end
  always_comb begin
    cpl_beat = {wd_flag_q ? data_q : 32'h0,
                req_rid, req_tag, 1'b0, lower_addr,
                cfg_completer_id, 3'b000, 1'b0, byte_count,
                1'b0, wd_flag_q ? CPLD : CPL, 1'b0, req_tc, 4'h0, req_td, req_ep, req_attr, 2'b00,
                wd_flag_q ? 10'd1 : 10'd0};
    mrd_beat = {32'h0,
                mrd_addr_q, 2'b00,
                cfg_completer_id, tag_q, mrd_len_q == 10'd1 ? 4'h0 : 4'hF, 4'hF,
                1'b0, MRD32, 14'h0, mrd_len_q};
    rd_en            = state_q == IDLE && compl_pending_q && wd_flag_q;
    rd_addr          = rd_en ? req_addr[12:2] : '0;
    dma_rd_ready     = state_q == IDLE && !compl_pending_q && !req_compl && dma_rd_valid;
    dma_rd_tag       = tag_q;
    s_axis_tx_tvalid = state_q == CPL_SEND || state_q == MRD_SEND;
    compl_done       = state_q == CPL_SEND && s_axis_tx_tready;
    s_axis_tx_tdata  = state_q == CPL_SEND ? cpl_beat : state_q == MRD_SEND ? mrd_beat : '0;
    s_axis_tx_tkeep  = state_q == CPL_SEND ? (wd_flag_q ? KEEP_4DW : KEEP_3DW) :
                       state_q == MRD_SEND ? KEEP_3DW : '0;
    s_axis_tx_tlast  = 1'b1;
    s_axis_tx_tuser  = 4'h0;
  end
endmodule

// File: tb/tb_xilinx_pcie_tx_ep.sv
// tb_xilinx_pcie_tx_ep: table-driven completions plus DMA, stall, priority, reset and tag-wrap sequences against a beat scoreboard
module tb_xilinx_pcie_tx_ep;
  localparam logic [15:0] CID = 16'hA5C3;
  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         cpl;
  } beat_t;
  typedef struct {
    logic        wd;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
    logic [11:0] bc;
    logic [1:0]  lo;
  } vec_t;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_compl, req_compl_wd, req_td, req_ep;
  logic [2:0]   req_tc;
  logic [1:0]   req_attr;
  logic [9:0]   req_len;
  logic [15:0]  req_rid;
  logic [7:0]   req_tag, req_be;
  logic [31:0]  req_addr;
  logic         compl_done, rd_en;
  logic [10:0]  rd_addr;
  logic [31:0]  rd_data = 32'h0;
  logic [31:0]  mem_word;
  logic         p1 = 1'b0;
  logic         dma_rd_valid, dma_rd_ready;
  logic [31:0]  dma_rd_addr;
  logic [9:0]   dma_rd_len;
  logic [7:0]   dma_rd_tag;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast, tvalid, tready;
  logic [3:0]   tuser;
  beat_t        sb_q[$];
  beat_t        e;
  vec_t         vecs[12];
  int           checks = 0;
  int           errors = 0;
  int           beats = 0;
  logic [7:0]   exp_tag = 8'h0;
  logic         stall_q = 1'b0;
  logic [127:0] pd;
  logic [15:0]  pk;
  xilinx_pcie_tx_ep #(.P_DATA_WIDTH(128), .P_RD_LATENCY(2)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .cfg_completer_id (CID),
    .req_compl        (req_compl),
    .req_compl_wd     (req_compl_wd),
    .req_tc           (req_tc),
    .req_td           (req_td),
    .req_ep           (req_ep),
    .req_attr         (req_attr),
    .req_len          (req_len),
    .req_rid          (req_rid),
    .req_tag          (req_tag),
    .req_be           (req_be),
    .req_addr         (req_addr),
    .compl_done       (compl_done),
    .rd_addr          (rd_addr),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .dma_rd_valid     (dma_rd_valid),
    .dma_rd_ready     (dma_rd_ready),
    .dma_rd_addr      (dma_rd_addr),
    .dma_rd_len       (dma_rd_len),
    .dma_rd_tag       (dma_rd_tag),
    .s_axis_tx_tdata  (tdata),
    .s_axis_tx_tkeep  (tkeep),
    .s_axis_tx_tlast  (tlast),
    .s_axis_tx_tuser  (tuser),
    .s_axis_tx_tvalid (tvalid),
    .s_axis_tx_tready (tready)
  );
  always #5 clk = ~clk;
  // two-cycle read memory; data is garbage outside its single valid cycle
  always @(posedge clk) begin
    p1      <= rd_en;
    rd_data <= p1 ? mem_word : 32'hDEAD_BEEF;
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [127:0] exp_cpl(input logic wd, input logic [15:0] rid, input logic [7:0] tag,
                                           input logic [11:0] bc, input logic [6:0] la, input logic [31:0] d);
    logic [31:0] dw0;
    dw0 = {1'b0, wd ? 7'b100_1010 : 7'b000_1010, 1'b0, req_tc, 4'h0, req_td, req_ep, req_attr, 2'b00,
           wd ? 10'd1 : 10'd0};
    return {wd ? d : 32'h0, rid, tag, 1'b0, la, CID, 4'h0, bc, dw0};
  endfunction
  function automatic logic [127:0] exp_mrd(input logic [31:0] addr, input logic [9:0] len, input logic [7:0] tag);
    return {32'h0, addr[31:2], 2'b00, CID, tag, len == 10'd1 ? 4'h0 : 4'hF, 4'hF, 22'h0, len};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        chk("hold_tvalid", 128'(tvalid), 128'(1'b1));
        chk("hold_tdata", tdata, pd);
        chk("hold_tkeep", 128'(tkeep), 128'(pk));
      end
      if (rd_en) chk("rd_addr", 128'(rd_addr), 128'(req_addr[12:2]));
      if (tvalid && tready) begin
        beats++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none at %0t", tdata, $time);
        end else begin
          e = sb_q.pop_front();
          chk("tdata", tdata, e.data);
          chk("tkeep", 128'(tkeep), 128'(e.keep));
          chk("compl_done_hs", 128'(compl_done), 128'(e.cpl));
          chk("tlast", 128'(tlast), 128'(1'b1));
        end
      end else chk("compl_done_idle", 128'(compl_done), 128'(1'b0));
      stall_q = tvalid && !tready;
      pd      = tdata;
      pk      = tkeep;
    end
  end
  task automatic send_cpl(input logic wd, input logic [3:0] be, input logic [31:0] addr, input logic [7:0] tag,
                          input logic [15:0] rid, input logic [31:0] data, input logic [127:0] exp);
    @(posedge clk); #1;
    req_compl_wd = wd;
    req_be       = {4'h0, be};
    req_addr     = addr;
    req_tag      = tag;
    req_rid      = rid;
    mem_word     = data;
    req_compl    = 1'b1;
    sb_q.push_back('{exp, wd ? 16'hFFFF : 16'h0FFF, 1'b1});
    @(posedge clk); #1;
    req_compl = 1'b0;
  endtask
  task automatic dma_wait(input logic [31:0] addr, input logic [9:0] len);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dma_rd_ready && n < 100);
    chk("dma_accept", 128'(dma_rd_ready), 128'(1'b1));
    if (dma_rd_ready) begin
      chk("dma_tag", 128'(dma_rd_tag), 128'(exp_tag));
      sb_q.push_back('{exp_mrd(addr, len, exp_tag), 16'h0FFF, 1'b0});
      exp_tag++;
    end
    @(posedge clk); #1;
    dma_rd_valid = 1'b0;
  endtask
  task automatic dma_req(input logic [31:0] addr, input logic [9:0] len);
    @(posedge clk); #1;
    dma_rd_valid = 1'b1;
    dma_rd_addr  = addr;
    dma_rd_len   = len;
    dma_wait(addr, len);
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 128'(sb_q.size()), 128'(0));
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 128'(tvalid), 128'(1'b1));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int b0;
    vecs[0]  = '{1'b1, 4'h1, 32'h0000_0104, 32'h1111_0001, 12'd1, 2'd0};
    vecs[1]  = '{1'b1, 4'h3, 32'h0000_107C, 32'h2222_0002, 12'd2, 2'd0};
    vecs[2]  = '{1'b1, 4'h6, 32'h0000_0020, 32'h3333_0003, 12'd2, 2'd1};
    vecs[3]  = '{1'b1, 4'h8, 32'h1234_5648, 32'h4444_0004, 12'd1, 2'd3};
    vecs[4]  = '{1'b0, 4'hC, 32'h0000_0010, 32'h5555_0005, 12'd2, 2'd2};
    vecs[5]  = '{1'b1, 4'h9, 32'hFFFF_FFFC, 32'h6666_0006, 12'd4, 2'd0};
    vecs[6]  = '{1'b0, 4'h0, 32'h0000_0044, 32'h7777_0007, 12'd1, 2'd0};
    vecs[7]  = '{1'b1, 4'h5, 32'h0000_0058, 32'h8888_0008, 12'd3, 2'd0};
    vecs[8]  = '{1'b1, 4'hA, 32'h0000_0034, 32'h9999_0009, 12'd3, 2'd1};
    vecs[9]  = '{1'b1, 4'h4, 32'h0000_0068, 32'hAAAA_000A, 12'd1, 2'd2};
    vecs[10] = '{1'b0, 4'h7, 32'h0000_000C, 32'hBBBB_000B, 12'd3, 2'd0};
    vecs[11] = '{1'b1, 4'hE, 32'h0000_0070, 32'hCCCC_000C, 12'd3, 2'd1};
    rst_n = 1'b0; req_compl = 1'b0; req_compl_wd = 1'b0; req_tc = 3'd0; req_td = 1'b0; req_ep = 1'b0;
    req_attr = 2'd0; req_len = 10'd1; req_rid = 16'h0; req_tag = 8'h0; req_be = 8'h0; req_addr = 32'h0;
    mem_word = 32'h0; dma_rd_valid = 1'b0; dma_rd_addr = 32'h0; dma_rd_len = 10'd0; tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 128'(tvalid), 128'(1'b0));
    chk("rst_tdata", tdata, 128'h0);
    chk("rst_tkeep", 128'(tkeep), 128'(0));
    chk("rst_compl_done", 128'(compl_done), 128'(1'b0));
    chk("rst_rd_en", 128'(rd_en), 128'(1'b0));
    chk("rst_rd_addr", 128'(rd_addr), 128'(0));
    chk("rst_dma_ready", 128'(dma_rd_ready), 128'(1'b0));
    chk("rst_dma_tag", 128'(dma_rd_tag), 128'(0));
    chk("rst_tuser", 128'(tuser), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_cpl(1'b1, 4'hF, 32'h0000_0104, 8'h12, 16'hBEEF, 32'hCAFE_F00D,
             {32'hCAFE_F00D, 32'hBEEF_1204, CID, 16'h0004, 32'h4A00_0001});
    drain("main_cpld_drain");
    req_tc = 3'b011; req_td = 1'b1; req_ep = 1'b1; req_attr = 2'b10;
    for (int i = 0; i < 12; i++) begin
      send_cpl(vecs[i].wd, vecs[i].be, vecs[i].addr, 8'(8'h40 + i), 16'(16'h1000 + i), vecs[i].data,
               exp_cpl(vecs[i].wd, 16'(16'h1000 + i), 8'(8'h40 + i), vecs[i].bc,
                       {vecs[i].addr[6:2], vecs[i].lo}, vecs[i].data));
      drain("table_drain");
    end
    dma_req(32'h1000_0040, 10'd16);
    dma_req(32'h1000_0040, 10'd16);
    dma_req(32'h1000_0083, 10'd1);
    dma_req(32'h1000_0100, 10'd0);
    drain("dma_drain");
    @(posedge clk); #1;
    tready = 1'b0;
    send_cpl(1'b1, 4'h3, 32'h0000_0208, 8'h77, 16'h0102, 32'h89AB_CDEF,
             exp_cpl(1'b1, 16'h0102, 8'h77, 12'd2, 7'h08, 32'h89AB_CDEF));
    wait_valid("stall_valid");
    repeat (5) @(negedge clk);
    chk("stall_queue", 128'(sb_q.size()), 128'(1));
    @(posedge clk); #1;
    tready = 1'b1;
    drain("stall_drain");
    @(posedge clk); #1;
    req_compl_wd = 1'b1; req_be = 8'h0F; req_addr = 32'h0000_0300; req_tag = 8'h21; req_rid = 16'h3344;
    mem_word = 32'h0BAD_F00D; req_compl = 1'b1;
    dma_rd_valid = 1'b1; dma_rd_addr = 32'h3000_0100; dma_rd_len = 10'd8;
    sb_q.push_back('{exp_cpl(1'b1, 16'h3344, 8'h21, 12'd4, 7'h00, 32'h0BAD_F00D), 16'hFFFF, 1'b1});
    @(negedge clk);
    chk("simul_ready_low", 128'(dma_rd_ready), 128'(1'b0));
    @(posedge clk); #1;
    req_compl = 1'b0;
    dma_wait(32'h3000_0100, 10'd8);
    drain("simul_drain");
    @(posedge clk); #1;
    tready = 1'b0;
    dma_req(32'h4000_0010, 10'd4);
    wait_valid("mrd_stall_valid");
    send_cpl(1'b1, 4'hF, 32'h0000_0050, 8'h09, 16'h0A0B, 32'h1357_9BDF,
             exp_cpl(1'b1, 16'h0A0B, 8'h09, 12'd4, 7'h50, 32'h1357_9BDF));
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    tready = 1'b1;
    drain("mrd_stall_drain");
    @(posedge clk); #1;
    tready = 1'b0;
    send_cpl(1'b0, 4'h1, 32'h0000_0060, 8'h5A, 16'h7788, 32'h0,
             exp_cpl(1'b0, 16'h7788, 8'h5A, 12'd1, 7'h60, 32'h0));
    wait_valid("rst_mid_valid");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_tvalid", 128'(tvalid), 128'(1'b0));
    chk("rst_async_compl_done", 128'(compl_done), 128'(1'b0));
    sb_q.delete();
    exp_tag = 8'h0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tready = 1'b1;
    b0 = beats;
    repeat (10) @(negedge clk);
    chk("rst_no_beat", 128'(beats), 128'(b0));
    chk("rst_idle_tvalid", 128'(tvalid), 128'(1'b0));
    chk("rst_tag_cleared", 128'(dma_rd_tag), 128'(0));
    for (int i = 0; i < 257; i++)
      dma_req(32'h2000_0000 + 32'(i * 16), 10'(i % 3 == 0 ? 1 : i));
    drain("wrap_drain");
    chk("wrap_next_tag", 128'(dma_rd_tag), 128'(8'h01));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
